sw_seq_packer: RTL
==================

SW_SEQ_PACKER -- requirements
Module: sw_seq_packer

Interface
REQ-001 Parameter MAX_LENGTH, default 128, SHALL set the maximum bases per sequence; sequence bus width is 2*MAX_LENGTH.
REQ-002 Ports SHALL be:
  avm_clk  in  1  clock; all logic on rising edge
  avm_rst  in  1  reset, synchronous, active-high
  i_byte  in  8  ASCII stream byte from UART wrapper
  i_byte_valid  in  1  i_byte valid
  o_byte_ready  out  1  byte accepted when i_byte_valid & o_byte_ready
  o_valid  out  1  packed pair available to SW core
  i_ready  in  1  core accepts pair when o_valid & i_ready
  o_sequence_ref  out  2*MAX_LENGTH  packed reference
  o_sequence_read  out  2*MAX_LENGTH  packed read
  o_seq_ref_length  out  8  reference length in bases
  o_seq_read_length  out  8  read length in bases
  o_err  out  1  one-cycle malformed-frame pulse
REQ-003 Clock is avm_clk only; reset is avm_rst, synchronous, active-high.

Function
REQ-004 Frame format SHALL be: byte0 = ref length L1, byte1 = read length L2, then L1 ref chars, then L2 read chars.
REQ-005 Encoding SHALL be A=00, C=01, G=10, T=11; lowercase equivalent (bit 5 ignored).
REQ-006 Base k (0-based) of a sequence SHALL occupy bits [2*MAX_LENGTH-1-2k -: 2]; all bits beyond the length SHALL be 0.
REQ-007 FSM states: S_REF_LEN -> S_READ_LEN -> S_REF -> S_READ -> S_OUT -> S_REF_LEN.
REQ-008 A state advances only on an accepted byte; S_REF exits after the L1-th char, S_READ after the L2-th char.
REQ-009 o_byte_ready SHALL be 1 in all states except S_OUT.
REQ-010 o_valid SHALL rise the cycle after the final read char is accepted (latency 1) and hold until i_ready.
REQ-011 While o_valid=1, all o_sequence_*/o_seq_*_length outputs SHALL be stable.
REQ-012 Handshake in S_OUT SHALL clear o_valid next cycle, clear both sequence registers, and enter S_REF_LEN.
REQ-013 i_ready while o_valid=0 SHALL have no effect; i_byte_valid without o_byte_ready SHALL be ignored.
REQ-014 Base counter SHALL be 8 bits, reset to 0 at each length byte and each sequence boundary; no wrap occurs because lengths are bounded by MAX_LENGTH.
REQ-015 Maximum frame (128+128) SHALL produce exactly 2+256 accepted bytes before o_valid.

Reset
REQ-016 On avm_rst at a clock edge: state=S_REF_LEN, o_valid=0, o_err=0, o_byte_ready=1, sequences=0, lengths=0, counter=0.
REQ-017 Reset mid-frame or with o_valid held SHALL discard the partial/pending pair; no output handshake completes on the reset cycle.

Configuration
REQ-018 Macro SW_PACKER_ERR_CHECK_EN SHALL control error checking.
REQ-019 Defined: length byte 0 or >MAX_LENGTH, or char not in {A,C,G,T,a,c,g,t}, SHALL pulse o_err 1 cycle, discard the frame, and return to S_REF_LEN next cycle.
REQ-020 Undefined: o_err tied 0; invalid chars encode 00; length >MAX_LENGTH clamps to MAX_LENGTH, length 0 treated as 1.

Verification
REQ-021 Frame {4,3,"ACGT","TTA"} -> o_valid; ref bits[255:248]=8'b00011011, read bits[255:250]=6'b111100, rest 0; lengths 4/3.
REQ-022 128+128 frame of 'G' -> o_valid after 258 accepted bytes; both sequences = {128{2'b10}}; lengths 128/128.
REQ-023 i_ready=0 for 10 cycles after o_valid -> outputs stable, o_byte_ready=0, bytes ignored; i_ready=1 -> o_valid=0 next cycle.
REQ-024 With SW_PACKER_ERR_CHECK_EN: {2,2,"AX"} -> o_err pulse on cycle after 'X'; next frame {1,1,"C","G"} packs correctly.
REQ-025 Without SW_PACKER_ERR_CHECK_EN: length byte 200 -> treated as 128; char 'N' -> 00; o_err stays 0.
REQ-026 avm_rst asserted after 5 ref chars -> next cycle all outputs at reset values; fresh frame {1,1,"T","A"} yields ref MSBs 2'b11, read MSBs 2'b00.

Source files
------------

// File: rtl/sw_seq_packer.sv
// Packs an ASCII DNA frame {L1, L2, ref chars, read chars} into two 2-bit-per-base vectors for the SW core.
// Optional malformed-frame detection is enabled by defining SW_PACKER_ERR_CHECK_EN.
module sw_seq_packer #(
   parameter int MAX_LENGTH = 128
) (
   input  logic                      avm_clk,
   input  logic                      avm_rst,
   input  logic [7:0]                i_byte,
   input  logic                      i_byte_valid,
   output logic                      o_byte_ready,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic [2*MAX_LENGTH-1:0]   o_sequence_ref,
   output logic [2*MAX_LENGTH-1:0]   o_sequence_read,
   output logic [7:0]                o_seq_ref_length,
   output logic [7:0]                o_seq_read_length,
   output logic                      o_err
);

   localparam int SeqW = 2 * MAX_LENGTH;
   localparam logic [8:0] MaxLen9 = 9'(MAX_LENGTH);
   localparam logic [7:0] MaxLen8 = 8'(MAX_LENGTH);

`ifdef SW_PACKER_ERR_CHECK_EN
   localparam bit ErrCheckEn = 1'b1;
`else
   localparam bit ErrCheckEn = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_REF_LEN,
      S_READ_LEN,
      S_REF,
      S_READ,
      S_OUT
   } state_t;

   state_t            state_q;
   logic [SeqW-1:0]   refSeq_q, readSeq_q;
   logic [SeqW-1:0]   refSeq_d, readSeq_d;
   logic [7:0]        refLen_q, readLen_q;
   logic [7:0]        baseCnt_q;
   logic              valid_q, err_q, byteReady_q;

   logic              byteAccept;
   logic              lenBad, charBad, frameAbort;
   logic [7:0]        lenVal;
   logic [1:0]        charCode;

   // Base k lands MSB-first, so base 0 sits in the top two bits of the vector.
   function automatic logic [SeqW-1:0] placeBase(input logic [SeqW-1:0] seq,
                                                 input logic [1:0]      code,
                                                 input logic [7:0]      idx);
      logic [SeqW-1:0] slot;
      slot = {code, {(SeqW-2){1'b0}}} >> {idx, 1'b0};
      return seq | slot;
   endfunction

   always_comb begin
      byteAccept = i_byte_valid & byteReady_q;

      lenBad = (i_byte == 8'd0) || ({1'b0, i_byte} > MaxLen9);
      if (i_byte == 8'd0) begin
         lenVal = 8'd1;
      end else if ({1'b0, i_byte} > MaxLen9) begin
         lenVal = MaxLen8;
      end else begin
         lenVal = i_byte;
      end

      // Clearing bit 5 folds lowercase letters onto their uppercase codes.
      charBad  = 1'b0;
      charCode = 2'b00;
      case (i_byte & 8'hDF)
         8'h41:   charCode = 2'b00;
         8'h43:   charCode = 2'b01;
         8'h47:   charCode = 2'b10;
         8'h54:   charCode = 2'b11;
         default: charBad  = 1'b1;
      endcase

      refSeq_d  = placeBase(refSeq_q, charCode, baseCnt_q);
      readSeq_d = placeBase(readSeq_q, charCode, baseCnt_q);

      frameAbort = 1'b0;
      if (ErrCheckEn && byteAccept) begin
         if ((state_q == S_REF_LEN) || (state_q == S_READ_LEN)) begin
            frameAbort = lenBad;
         end else if ((state_q == S_REF) || (state_q == S_READ)) begin
            frameAbort = charBad;
         end
      end
   end

   // Frame FSM; every output comes straight from a register.
   always_ff @(posedge avm_clk) begin
      if (avm_rst) begin
         state_q     <= S_REF_LEN;
         refSeq_q    <= '0;
         readSeq_q   <= '0;
         refLen_q    <= 8'd0;
         readLen_q   <= 8'd0;
         baseCnt_q   <= 8'd0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
         byteReady_q <= 1'b1;
      end else begin
         err_q <= 1'b0;
         if (frameAbort) begin
            state_q   <= S_REF_LEN;
            refSeq_q  <= '0;
            readSeq_q <= '0;
            refLen_q  <= 8'd0;
            readLen_q <= 8'd0;
            baseCnt_q <= 8'd0;
            err_q     <= 1'b1;
         end else begin
            case (state_q)
               S_REF_LEN: begin
                  if (byteAccept) begin
                     refLen_q  <= lenVal;
                     baseCnt_q <= 8'd0;
                     state_q   <= S_READ_LEN;
                  end
               end
               S_READ_LEN: begin
                  if (byteAccept) begin
                     readLen_q <= lenVal;
                     baseCnt_q <= 8'd0;
                     state_q   <= S_REF;
                  end
               end
               S_REF: begin
                  if (byteAccept) begin
                     refSeq_q <= refSeq_d;
                     if (baseCnt_q == refLen_q - 8'd1) begin
                        baseCnt_q <= 8'd0;
                        state_q   <= S_READ;
                     end else begin
                        baseCnt_q <= baseCnt_q + 8'd1;
                     end
                  end
               end
               S_READ: begin
                  if (byteAccept) begin
                     readSeq_q <= readSeq_d;
                     if (baseCnt_q == readLen_q - 8'd1) begin
                        baseCnt_q   <= 8'd0;
                        state_q     <= S_OUT;
                        valid_q     <= 1'b1;
                        byteReady_q <= 1'b0;
                     end else begin
                        baseCnt_q <= baseCnt_q + 8'd1;
                     end
                  end
               end
               S_OUT: begin
                  if (valid_q && i_ready) begin
                     refSeq_q    <= '0;
                     readSeq_q   <= '0;
                     valid_q     <= 1'b0;
                     byteReady_q <= 1'b1;
                     state_q     <= S_REF_LEN;
                  end
               end
               default: begin
                  state_q     <= S_REF_LEN;
                  byteReady_q <= 1'b1;
                  valid_q     <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_byte_ready      = byteReady_q;
   assign o_valid           = valid_q;
   assign o_err             = err_q;
   assign o_sequence_ref    = refSeq_q;
   assign o_sequence_read   = readSeq_q;
   assign o_seq_ref_length  = refLen_q;
   assign o_seq_read_length = readLen_q;

endmodule
